// File: rtl/lane_tx_scheduler_if.sv
// Purpose : handshake/control bundle between the TX scheduler and its neighbours
//           (request side from OS generator / transport source, control side to distributer).
// Ports   : master = request driver / distributer observer, slave = scheduler.
interface lane_tx_scheduler_if;
    // request side
    logic       link_up;
    logic       os_req;
    logic [3:0] os_sel;
    logic       td_req;
    // grant / done pulses
    logic       os_gnt;
    logic       td_gnt;
    logic       os_done;
    logic       td_done;
    // distributer controls
    logic       enable_t;
    logic [3:0] d_sel;
    logic       data_os;
    logic       busy;

    modport master (
        output link_up, os_req, os_sel, td_req,
        input  os_gnt, td_gnt, os_done, td_done, enable_t, d_sel, data_os, busy
    );

    modport slave (
        input  link_up, os_req, os_sel, td_req,
        output os_gnt, td_gnt, os_done, td_done, enable_t, d_sel, data_os, busy
    );
endinterface

// File: rtl/lane_tx_scheduler.sv
// Purpose : arbitrates ordered-set bursts vs transport granules ahead of the two-lane distributer,
//           with OS priority bounded by a starvation limit.
// Latency : all outputs registered; request seen in IDLE -> grant pulse 1 clk later, bursts back-to-back.
// Backpr. : requests are levels sampled only at decision points; link_up low aborts to IDLE next clk.
// Ports   : clk, rst (sync, active-high), bus (slave modport: link_up/os_req/os_sel/td_req in;
//           os_gnt/td_gnt/os_done/td_done/enable_t/d_sel/data_os/busy out).
module lane_tx_scheduler #(
    parameter int OS_LEN     = 16,
    parameter int TD_GRAN    = 8,
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    lane_tx_scheduler_if.slave   bus
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    localparam logic [CNT_W-1:0] OS_LAST   = CNT_W'(OS_LEN - 1);
    localparam logic [CNT_W-1:0] TD_LAST   = CNT_W'(TD_GRAN - 1);
    localparam logic [SW-1:0]    STARVE_LIM = SW'(STARVE_MAX);

    localparam logic [3:0] SEL_TD   = 4'h8;
    localparam logic [3:0] SEL_IDLE = 4'h0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OS   = 2'd1,
        ST_TD   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SW-1:0]    starve_q, starve_d;

    logic             os_gnt_q, os_gnt_d;
    logic             td_gnt_q, td_gnt_d;
    logic             os_done_q, os_done_d;
    logic             td_done_q, td_done_d;
    logic             enable_t_q, enable_t_d;
    logic [3:0]       d_sel_q, d_sel_d;
    logic             data_os_q, data_os_d;
    logic             busy_q, busy_d;

    logic             last_os;
    logic             last_td;
    logic             dec_pt;
    logic             start;

    assign last_os = (state_q == ST_OS) && (cnt_q == OS_LAST);
    assign last_td = (state_q == ST_TD) && (cnt_q == TD_LAST);
    assign dec_pt  = (state_q == ST_IDLE) || last_os || last_td;

    // Next-state, counters and starvation tracking
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_W'(1);
        starve_d = starve_q;
        start    = 1'b0;

        if (!bus.link_up) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            starve_d = '0;
        end else if (dec_pt) begin
            cnt_d = '0;
            if (!bus.td_req) begin
                starve_d = '0;
            end
            // enable_t_q low means the link has only just come back: the distributer must
            // see one enabled cycle before any burst starts.
            if (!enable_t_q) begin
                state_d = ST_IDLE;
            end else if (bus.os_req && !(bus.td_req && (starve_q == STARVE_LIM))) begin
                state_d = ST_OS;
                start   = 1'b1;
                if (bus.td_req && (starve_q != STARVE_LIM)) begin
                    starve_d = starve_q + SW'(1);
                end
            end else if (bus.td_req) begin
                state_d  = ST_TD;
                start    = 1'b1;
                starve_d = '0;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    // Registered outputs derived from where the FSM is heading
    always_comb begin
        os_gnt_d   = start && (state_d == ST_OS);
        td_gnt_d   = start && (state_d == ST_TD);
        os_done_d  = (state_d == ST_OS) && (cnt_d == OS_LAST);
        td_done_d  = (state_d == ST_TD) && (cnt_d == TD_LAST);
        enable_t_d = bus.link_up;
        data_os_d  = (state_d == ST_TD);
        busy_d     = (state_d != ST_IDLE);
        d_sel_d    = SEL_IDLE;

        case (state_d)
            ST_OS: begin
                // The type code is captured once per burst; the reserved transport code
                // must never reach the distributer as an OS selection.
                if (start) begin
                    d_sel_d = (bus.os_sel == SEL_TD) ? SEL_IDLE : bus.os_sel;
                end else begin
                    d_sel_d = d_sel_q;
                end
            end
            ST_TD:   d_sel_d = SEL_TD;
            default: d_sel_d = SEL_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            starve_q   <= '0;
            os_gnt_q   <= 1'b0;
            td_gnt_q   <= 1'b0;
            os_done_q  <= 1'b0;
            td_done_q  <= 1'b0;
            enable_t_q <= 1'b0;
            d_sel_q    <= SEL_IDLE;
            data_os_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            starve_q   <= starve_d;
            os_gnt_q   <= os_gnt_d;
            td_gnt_q   <= td_gnt_d;
            os_done_q  <= os_done_d;
            td_done_q  <= td_done_d;
            enable_t_q <= enable_t_d;
            d_sel_q    <= d_sel_d;
            data_os_q  <= data_os_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.os_gnt   = os_gnt_q;
    assign bus.td_gnt   = td_gnt_q;
    assign bus.os_done  = os_done_q;
    assign bus.td_done  = td_done_q;
    assign bus.enable_t = enable_t_q;
    assign bus.d_sel    = d_sel_q;
    assign bus.data_os  = data_os_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_lane_tx_scheduler.sv
module tb_lane_tx_scheduler;

    localparam int OS_LEN     = 16;
    localparam int TD_GRAN    = 8;
    localparam int STARVE_MAX = 4;
    localparam int CNT_W      = 5;

    typedef struct packed {
        logic       os_gnt;
        logic       td_gnt;
        logic       os_done;
        logic       td_done;
        logic       enable_t;
        logic [3:0] d_sel;
        logic       data_os;
        logic       busy;
    } exp_t;

    logic clk;
    logic rst;
    lane_tx_scheduler_if ifc ();

    exp_t exp_q[$];
    int   vectors;
    int   miscompares;

    lane_tx_scheduler #(
        .OS_LEN     (OS_LEN),
        .TD_GRAN    (TD_GRAN),
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t obs();
        exp_t o;
        o.os_gnt   = ifc.os_gnt;
        o.td_gnt   = ifc.td_gnt;
        o.os_done  = ifc.os_done;
        o.td_done  = ifc.td_done;
        o.enable_t = ifc.enable_t;
        o.d_sel    = ifc.d_sel;
        o.data_os  = ifc.data_os;
        o.busy     = ifc.busy;
        return o;
    endfunction

    // Expected-vector generators: one entry per clock, straight from the burst definitions.
    function automatic void push_idle(int n, logic en);
        for (int c = 0; c < n; c++) exp_q.push_back('{1'b0, 1'b0, 1'b0, 1'b0, en, 4'h0, 1'b0, 1'b0});
    endfunction

    function automatic void push_os(logic [3:0] sel, int n);
        for (int c = 0; c < n; c++)
            exp_q.push_back('{(c == 0), 1'b0, (c == OS_LEN - 1), 1'b0, 1'b1, sel, 1'b0, 1'b1});
    endfunction

    function automatic void push_td(int n);
        for (int c = 0; c < n; c++)
            exp_q.push_back('{1'b0, (c == 0), 1'b0, (c == TD_GRAN - 1), 1'b1, 4'h8, 1'b1, 1'b1});
    endfunction

    task automatic test_reset();
        exp_t e, got;
        rst = 1'b1;
        ifc.link_up = 1'b1;
        ifc.os_req = 1'b0;
        ifc.td_req = 1'b0;
        ifc.os_sel = 4'h0;
        push_idle(2, 1'b0);
        push_idle(3, 1'b1);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(posedge clk); #1;
            e = exp_q.pop_front(); got = obs(); vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL reset cyc %0d: got %b want %b", i, got, e);
            end
            if (i == 1) rst = 1'b0;
        end
    endtask

    task automatic test_os_single();
        exp_t e, got;
        ifc.os_sel = 4'h3;
        ifc.os_req = 1'b1;
        push_os(4'h3, OS_LEN);
        push_idle(2, 1'b1);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(posedge clk); #1;
            e = exp_q.pop_front(); got = obs(); vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL os_single cyc %0d: got %b want %b", i, got, e);
            end
            if (i == 0) ifc.os_req = 1'b0;
        end
    endtask

    task automatic test_td_stream();
        exp_t e, got;
        ifc.td_req = 1'b1;
        for (int g = 0; g < 3; g++) push_td(TD_GRAN);
        push_idle(2, 1'b1);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(posedge clk); #1;
            e = exp_q.pop_front(); got = obs(); vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL td_stream cyc %0d: got %b want %b", i, got, e);
            end
            if (i == 3 * TD_GRAN - 1) ifc.td_req = 1'b0;
        end
    endtask

    task automatic test_starve();
        exp_t e, got;
        int   last;
        ifc.os_sel = 4'h5;
        ifc.os_req = 1'b1;
        ifc.td_req = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int b = 0; b < STARVE_MAX; b++) push_os(4'h5, OS_LEN);
            push_td(TD_GRAN);
        end
        last = exp_q.size() - 1;
        push_idle(2, 1'b1);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(posedge clk); #1;
            e = exp_q.pop_front(); got = obs(); vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL starve cyc %0d: got %b want %b", i, got, e);
            end
            // os_sel wiggles mid-burst; the burst must keep the value latched at grant
            if (i == 3)  ifc.os_sel = 4'hA;
            if (i == 14) ifc.os_sel = 4'h5;
            if (i == last) begin
                ifc.os_req = 1'b0;
                ifc.td_req = 1'b0;
            end
        end
    endtask

    task automatic test_link_drop();
        exp_t e, got;
        ifc.td_req = 1'b1;
        push_td(6);            // cnt 0..5, then abort
        push_idle(2, 1'b0);    // link down: no td_done, enable_t low
        push_idle(1, 1'b1);    // enable_t back, grant still blocked
        push_td(TD_GRAN);
        push_idle(2, 1'b1);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(posedge clk); #1;
            e = exp_q.pop_front(); got = obs(); vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL link_drop cyc %0d: got %b want %b", i, got, e);
            end
            if (i == 5)  ifc.link_up = 1'b0;
            if (i == 7)  ifc.link_up = 1'b1;
            if (i == 16) ifc.td_req = 1'b0;
        end
    endtask

    task automatic test_os_reserved();
        exp_t e, got;
        ifc.os_sel = 4'h8;
        ifc.os_req = 1'b1;
        push_os(4'h0, OS_LEN);
        push_idle(2, 1'b1);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(posedge clk); #1;
            e = exp_q.pop_front(); got = obs(); vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL os_reserved cyc %0d: got %b want %b", i, got, e);
            end
            if (i == 0) ifc.os_req = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        exp_t e, got;
        ifc.os_sel = 4'h7;
        ifc.os_req = 1'b1;
        push_os(4'h7, OS_LEN);
        push_td(TD_GRAN);
        push_idle(2, 1'b1);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(posedge clk); #1;
            e = exp_q.pop_front(); got = obs(); vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL back_to_back cyc %0d: got %b want %b", i, got, e);
            end
            if (i == 0) begin
                ifc.os_req = 1'b0;
                ifc.td_req = 1'b1;
            end
            if (i == OS_LEN + TD_GRAN - 1) ifc.td_req = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        exp_t e, got;
        ifc.os_sel = 4'h2;
        ifc.os_req = 1'b1;
        push_os(4'h2, 4);
        push_idle(1, 1'b0);    // reset wins over pending request
        push_idle(2, 1'b1);
        for (int i = 0; exp_q.size() > 0; i++) begin
            @(posedge clk); #1;
            e = exp_q.pop_front(); got = obs(); vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL reset_mid cyc %0d: got %b want %b", i, got, e);
            end
            if (i == 3) rst = 1'b1;
            if (i == 4) begin
                rst = 1'b0;
                ifc.os_req = 1'b0;
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        ifc.link_up = 1'b1;
        ifc.os_req  = 1'b0;
        ifc.td_req  = 1'b0;
        ifc.os_sel  = 4'h0;

        test_reset();
        test_os_single();
        test_td_stream();
        test_starve();
        test_link_drop();
        test_os_reserved();
        test_back_to_back();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
